seq_frame_tx: RTL and testbench

SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

---
 rtl/seq_frame_pkg.sv | 26 ++
 rtl/seq_frame_tx.sv | 81 ++++++++
 tb/tb_seq_frame_tx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/seq_frame_pkg.sv
// Shared types and constants for the serial frame transmitter.
package seq_frame_pkg;

  localparam int DATA_W = 8;
  localparam logic [2:0] PREAMBLE = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    PAR,
    GUARD
  } state_t;

  // Preamble goes out MSB first: index 0 selects PREAMBLE[2].
  function automatic logic preamble_bit(input logic [2:0] idx);
    logic b;
    case (idx)
      3'd0:    b = PREAMBLE[2];
      3'd1:    b = PREAMBLE[1];
      default: b = PREAMBLE[0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/seq_frame_tx.sv
// Serial framer: 101 preamble, MSB-first byte, optional even parity, guard zeros.
// First bit appears the cycle after the accept edge; in_ready only in IDLE, so producers stall a whole frame.
module seq_frame_tx
  import seq_frame_pkg::*;
#(
  parameter int GUARD_BITS = 2,
  parameter int PARITY_EN  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [2:0] GUARD_LAST = 3'(GUARD_BITS - 1);

  state_t            state, next_state;
  logic [2:0]        cnt, cnt_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic              out_next;
  logic              xfer;

  assign xfer = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (xfer) next_state = PRE;
      PRE:     if (cnt == 3'd2) next_state = DATA;
      DATA:    if (cnt == 3'd7) next_state = (PARITY_EN != 0) ? PAR : GUARD;
      PAR:     next_state = GUARD;
      GUARD:   if (cnt == GUARD_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE) && !reset;
    busy       = (state != IDLE);
    frame_done = (state == GUARD) && (cnt == GUARD_LAST);
  end

  // out is registered, so it is computed from the state the line will be in next cycle.
  // The byte rotates rather than shifts, leaving it intact for the parity bit after 8 steps.
  always_comb begin
    cnt_next   = ((next_state != state) || (state == IDLE)) ? 3'd0 : cnt + 3'd1;
    shreg_next = shreg;
    if (xfer)
      shreg_next = in_data;
    else if (state == DATA)
      shreg_next = {shreg[DATA_W-2:0], shreg[DATA_W-1]};
    case (next_state)
      PRE:     out_next = preamble_bit(cnt_next);
      DATA:    out_next = shreg_next[DATA_W-1];
      PAR:     out_next = ^shreg_next;
      default: out_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= 3'd0;
      shreg <= '0;
      out   <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      shreg <= shreg_next;
      out   <= out_next;
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Scoreboard bench: default instance (parity, 2 guard bits) and a no-parity, 3-guard-bit instance.
module tb_seq_frame_tx;

  typedef struct packed {
    logic rdy;
    logic busy;
    logic o;
    logic done;
    logic pre3;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid_a, in_valid_b;
  logic [7:0] in_data_a, in_data_b;
  logic       in_ready_a, out_a, busy_a, frame_done_a;
  logic       in_ready_b, out_b, busy_b, frame_done_b;

  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic [2:0] det_a = 3'b000;
  logic [2:0] det_b = 3'b000;

  always #5 clk = ~clk;

  seq_frame_tx u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_data(in_data_a),
    .in_ready(in_ready_a), .out(out_a), .busy(busy_a), .frame_done(frame_done_a)
  );

  seq_frame_tx #(.GUARD_BITS(3), .PARITY_EN(0)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .out(out_b), .busy(busy_b), .frame_done(frame_done_b)
  );

  function automatic exp_t mk(input logic r, input logic b, input logic o,
                              input logic d, input logic p);
    exp_t e;
    e.rdy = r; e.busy = b; e.o = o; e.done = d; e.pre3 = p;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got rdy/busy/out/done=%b want %b", name, $time, act, want);
    end
  endtask

  task automatic push_ent(input int which, input exp_t e);
    if (which == 0) qa.push_back(e);
    else            qb.push_back(e);
  endtask

  // 14-bit hand-computed frame, first bit in bits[13]; done on the last, detector hit on the third.
  task automatic push_frame(input int which, input logic [13:0] bits);
    for (int i = 13; i >= 0; i--)
      push_ent(which, mk(1'b0, 1'b1, bits[i], (i == 0), (i == 11)));
  endtask

  task automatic drain(input int which);
    int n;
    n = 0;
    while (((which == 0) ? qa.size() : qb.size()) > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (((which == 0) ? qa.size() : qb.size()) > 0) begin
      errors++;
      $display("FAIL drain_timeout dut=%0d: %0d entries left, want 0", which,
               (which == 0) ? qa.size() : qb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int which, input logic [7:0] d, input logic [13:0] bits);
    if (which == 0) begin in_valid_a = 1'b1; in_data_a = d; end
    else            begin in_valid_b = 1'b1; in_data_b = d; end
    @(posedge clk);
    #1;
    if (which == 0) begin in_valid_a = 1'b0; in_data_a = ~d; end
    else            begin in_valid_b = 1'b0; in_data_b = ~d; end
    push_frame(which, bits);
    drain(which);
  endtask

  // Monitors also model a loopback 101 detector on each serial line.
  always @(negedge clk) begin
    if (mon_en) begin
      det_a = {det_a[1:0], out_a};
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        cmp("a_cycle", {in_ready_a, busy_a, out_a, frame_done_a},
            {ea.rdy, ea.busy, ea.o, ea.done});
        if (ea.pre3) cmp("a_det101", {3'b000, det_a == 3'b101}, 4'b0001);
      end else begin
        cmp("a_idle", {1'b0, busy_a, out_a, frame_done_a}, 4'b0000);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      det_b = {det_b[1:0], out_b};
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        cmp("b_cycle", {in_ready_b, busy_b, out_b, frame_done_b},
            {eb.rdy, eb.busy, eb.o, eb.done});
        if (eb.pre3) cmp("b_det101", {3'b000, det_b == 3'b101}, 4'b0001);
      end else begin
        cmp("b_idle", {1'b0, busy_b, out_b, frame_done_b}, 4'b0000);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    in_valid_a = 1'b0; in_data_a = 8'h00;
    in_valid_b = 1'b0; in_data_b = 8'h00;

    // Reset state: idle, line low, in_ready held low while reset is high.
    @(posedge clk); #1;
    push_ent(0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    push_ent(1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    mon_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    push_ent(0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    push_ent(1, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;

    // 0xA5: 101 10100101 p=0 00
    send(0, 8'hA5, 14'b10110100101000);
    // 0x01: 101 00000001 p=1 00
    send(0, 8'h01, 14'b10100000001100);
    // No parity, 3 guard: 0xFF and 0x00
    send(1, 8'hFF, 14'b10111111111000);
    send(1, 8'h00, 14'b10100000000000);

    // Back-to-back 0x3C then 0xC3 with in_valid held; in_data scrambled mid-frame.
    in_valid_a = 1'b1; in_data_a = 8'h3C;
    @(posedge clk); #1;
    push_frame(0, 14'b10100111100000);
    push_ent(0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    push_frame(0, 14'b10111000011000);
    in_data_a = 8'h5A;
    repeat (10) @(posedge clk);
    #1;
    in_data_a = 8'hC3;
    repeat (5) @(posedge clk);
    #1;
    in_valid_a = 1'b0; in_data_a = 8'h00;
    drain(0);

    // Reset while data bit index 4 of 0xA5 is on the line: abort, no frame_done.
    in_valid_a = 1'b1; in_data_a = 8'hA5;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    push_ent(0, mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    push_ent(0, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    push_ent(0, mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    push_ent(0, mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    push_ent(0, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    push_ent(0, mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    push_ent(0, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    push_ent(0, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    push_ent(0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      push_ent(0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drain(0);
    drain(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
